// File: rtl/bpi_cmd_seq.sv
// Command sequencer for the BPI flash interface FSM: expands one flash command
// into ordered single bus cycles and polls the status register for program/erase.
module bpi_cmd_seq #(
  parameter int ADDR_W   = 23,
  parameter int POLL_MAX = 4095,
  parameter int POLL_CW  = 12,
  parameter int ACK_MAX  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [2:0]        CMD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       WDATA,
  output logic              SEQ_BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              TMO,
  output logic [7:0]        STATUS,
  output logic [15:0]       RDATA,
  output logic              BPI_EXECUTE,
  output logic              BPI_READ,
  output logic              BPI_WRITE,
  output logic [ADDR_W-1:0] BPI_ADDR,
  output logic [15:0]       BPI_DOUT,
  input  logic              BPI_BUSY,
  input  logic              BPI_LOAD,
  input  logic [15:0]       BPI_DIN,
  output logic [2:0]        dbg_state
);

  // Bus handshake: BPI_EXECUTE pulses one cycle with READ/WRITE, ADDR and DOUT
  // already stable; the interface FSM owns the cycle while BPI_BUSY=1, flags read
  // data with BPI_LOAD, and the cycle is over once BPI_BUSY falls back to 0.

  localparam logic [2:0] C_RDA   = 3'd0;
  localparam logic [2:0] C_RDS   = 3'd1;
  localparam logic [2:0] C_CLR   = 3'd2;
  localparam logic [2:0] C_PROG  = 3'd3;
  localparam logic [2:0] C_ERASE = 3'd4;
  localparam logic [2:0] C_UNLK  = 3'd5;
  localparam logic [2:0] C_LOCK  = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;
  localparam int ACK_CW = $clog2(ACK_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_ACK    = 3'd2,
    S_CMPL   = 3'd3,
    S_EVAL   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [1:0]          step_q, step_d;
  logic [POLL_CW-1:0]  poll_q, poll_d, poll_nxt;
  logic [ACK_CW-1:0]   ack_q, ack_d;
  logic                seq_busy_q, seq_busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;
  logic [7:0]          status_q, status_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                exec_q, exec_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dout_q, dout_d;
  logic                fin, fin_err, fin_tmo, issue, issue_rd;

  // Write data for step 0 (command code) or step 1 (second write) of a command.
  function automatic logic [15:0] write_data(input logic [2:0] cmd, input logic second,
                                             input logic [15:0] wdata);
    logic [15:0] d;
    d = 16'h0000;
    if (!second) begin
      case (cmd)
        C_RDA:          d = 16'h00FF;
        C_RDS:          d = 16'h0070;
        C_CLR:          d = 16'h0050;
        C_PROG:         d = 16'h0040;
        C_ERASE:        d = 16'h0020;
        C_UNLK, C_LOCK: d = 16'h0060;
        default:        d = 16'h0000;
      endcase
    end else begin
      case (cmd)
        C_PROG:          d = wdata;
        C_ERASE, C_UNLK: d = 16'h00D0;
        C_LOCK:          d = 16'h0001;
        default:         d = 16'h0000;
      endcase
    end
    return d;
  endfunction

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    step_d     = step_q;
    poll_d     = poll_q;
    poll_nxt   = poll_q + POLL_CW'(1);
    ack_d      = ack_q;
    seq_busy_d = seq_busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    tmo_d      = tmo_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    exec_d     = 1'b0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_tmo    = 1'b0;
    issue      = 1'b0;
    issue_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          cmd_d      = CMD;
          addr_d     = ADDR;
          wdata_d    = WDATA;
          err_d      = 1'b0;
          tmo_d      = 1'b0;
          step_d     = 2'd0;
          poll_d     = '0;
          seq_busy_d = 1'b1;
          if (CMD == C_RSVD) begin
            state_d = S_EVAL;
          end else begin
            state_d = S_ISSUE;
            exec_d  = 1'b1;
            wr_d    = 1'b1;
            rd_d    = 1'b0;
            dout_d  = write_data(CMD, 1'b0, WDATA);
          end
        end
      end
      S_ISSUE: begin
        ack_d   = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (BPI_BUSY) begin
          state_d = S_CMPL;
        end else if (ack_q == ACK_CW'(ACK_MAX - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_tmo = 1'b1;
        end else begin
          ack_d = ack_q + ACK_CW'(1);
        end
      end
      S_CMPL: begin
        if (BPI_LOAD) begin
          if (cmd_q == C_RDA) rdata_d = BPI_DIN;
          else                status_d = BPI_DIN[7:0];
        end
        if (!BPI_BUSY) begin
          state_d = S_EVAL;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_EVAL: begin
        if (cmd_q == C_RSVD) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (step_q == 2'd0) begin
          if (cmd_q == C_CLR) begin
            fin = 1'b1;
          end else begin
            issue    = 1'b1;
            issue_rd = (cmd_q == C_RDA) || (cmd_q == C_RDS);
            step_d   = 2'd1;
          end
        end else if (step_q == 2'd1 && cmd_q != C_PROG && cmd_q != C_ERASE) begin
          fin = 1'b1;
        end else if (step_q == 2'd1) begin
          issue    = 1'b1;
          issue_rd = 1'b1;
          step_d   = 2'd2;
        end else if (status_q[7]) begin
          // Ready: VPP, program, erase and lock errors all fold into ERR.
          fin     = 1'b1;
          fin_err = status_q[5] | status_q[4] | status_q[3] | status_q[1];
        end else begin
          poll_d = poll_nxt;
          if (poll_nxt == POLL_CW'(POLL_MAX)) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            fin_tmo = 1'b1;
          end else begin
            issue    = 1'b1;
            issue_rd = 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      state_d = S_ISSUE;
      exec_d  = 1'b1;
      rd_d    = issue_rd;
      wr_d    = !issue_rd;
      if (!issue_rd) dout_d = write_data(cmd_q, 1'b1, wdata_q);
    end

    if (fin) begin
      state_d    = S_FINISH;
      done_d     = 1'b1;
      seq_busy_d = 1'b0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      if (fin_err) err_d = 1'b1;
      if (fin_tmo) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      wdata_q    <= '0;
      step_q     <= '0;
      poll_q     <= '0;
      ack_q      <= '0;
      seq_busy_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      status_q   <= '0;
      rdata_q    <= '0;
      exec_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      step_q     <= step_d;
      poll_q     <= poll_d;
      ack_q      <= ack_d;
      seq_busy_q <= seq_busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      exec_q     <= exec_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  assign SEQ_BUSY    = seq_busy_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign TMO         = tmo_q;
  assign STATUS      = status_q;
  assign RDATA       = rdata_q;
  assign BPI_EXECUTE = exec_q;
  assign BPI_READ    = rd_q;
  assign BPI_WRITE   = wr_q;
  assign BPI_ADDR    = addr_q;
  assign BPI_DOUT    = dout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bpi_cmd_seq.sv
// Bench for bpi_cmd_seq: a behavioural interface-FSM responder, a bus-cycle
// scoreboard, a table of command vectors and hand-written corner sequences.
module tb_bpi_cmd_seq;

  localparam int AW       = 23;
  localparam int BW       = 1 + AW + 16;
  localparam int ACK_MAX  = 8;
  localparam int POLL_MAX = 4;
  localparam int NV       = 11;

  logic          CLK, RST, START;
  logic [2:0]    CMD;
  logic [AW-1:0] ADDR;
  logic [15:0]   WDATA;
  logic          SEQ_BUSY, DONE, ERR, TMO;
  logic [7:0]    STATUS;
  logic [15:0]   RDATA;
  logic          BPI_EXECUTE, BPI_READ, BPI_WRITE;
  logic [AW-1:0] BPI_ADDR;
  logic [15:0]   BPI_DOUT;
  logic          BPI_BUSY, BPI_LOAD;
  logic [15:0]   BPI_DIN;
  logic [2:0]    dbg_state;

  bpi_cmd_seq #(.ADDR_W(AW), .POLL_MAX(POLL_MAX), .POLL_CW(12), .ACK_MAX(ACK_MAX)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CMD(CMD), .ADDR(ADDR), .WDATA(WDATA),
    .SEQ_BUSY(SEQ_BUSY), .DONE(DONE), .ERR(ERR), .TMO(TMO), .STATUS(STATUS),
    .RDATA(RDATA), .BPI_EXECUTE(BPI_EXECUTE), .BPI_READ(BPI_READ),
    .BPI_WRITE(BPI_WRITE), .BPI_ADDR(BPI_ADDR), .BPI_DOUT(BPI_DOUT),
    .BPI_BUSY(BPI_BUSY), .BPI_LOAD(BPI_LOAD), .BPI_DIN(BPI_DIN), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    int            n_resp;
    logic [15:0]   r0, r1, r2, r3;
    logic          err;
    logic          tmo;
    logic [7:0]    status;
    logic [15:0]   rdata;
    int            lat;
    int            reads;
  } vec_t;

  vec_t          vecs[NV];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] act_q[$];
  logic [15:0]   resp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            bus_ph = 0;
  logic          bus_act = 1'b0;
  logic          bus_rd = 1'b0;
  logic          stuck = 1'b0;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] enc(input logic rd, input logic [AW-1:0] a,
                                        input logic [15:0] d);
    return {rd, a, (rd ? 16'h0000 : d)};
  endfunction

  function automatic vec_t mk(input logic [2:0] c, input logic [AW-1:0] a,
                              input logic [15:0] w, input int nr,
                              input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input logic [15:0] r3,
                              input logic e, input logic t, input logic [7:0] st,
                              input logic [15:0] rd, input int lat, input int reads);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = w; v.n_resp = nr;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
    v.err = e; v.tmo = t; v.status = st; v.rdata = rd; v.lat = lat; v.reads = reads;
    return v;
  endfunction

  // Expected bus cycles of one command, straight from the command table.
  function automatic void build_expected(input logic [2:0] c, input logic [AW-1:0] a,
                                         input logic [15:0] w, input int reads);
    case (c)
      3'd0: exp_q.push_back(enc(1'b0, a, 16'h00FF));
      3'd1: exp_q.push_back(enc(1'b0, a, 16'h0070));
      3'd2: exp_q.push_back(enc(1'b0, a, 16'h0050));
      3'd3: begin exp_q.push_back(enc(1'b0, a, 16'h0040)); exp_q.push_back(enc(1'b0, a, w)); end
      3'd4: begin exp_q.push_back(enc(1'b0, a, 16'h0020)); exp_q.push_back(enc(1'b0, a, 16'h00D0)); end
      3'd5: begin exp_q.push_back(enc(1'b0, a, 16'h0060)); exp_q.push_back(enc(1'b0, a, 16'h00D0)); end
      3'd6: begin exp_q.push_back(enc(1'b0, a, 16'h0060)); exp_q.push_back(enc(1'b0, a, 16'h0001)); end
      default: ;
    endcase
    for (int k = 0; k < reads; k++) exp_q.push_back(enc(1'b1, a, 16'h0000));
  endfunction

  task automatic compare_bus(input string tag);
    logic [BW-1:0] e, a;
    check({tag, "_ncyc"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : {BW{1'b1}};
      check($sformatf("%s_cyc%0d", tag, k), 64'(a), 64'(e));
    end
    act_q.delete();
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({SEQ_BUSY, DONE, ERR, TMO, BPI_EXECUTE, BPI_READ, BPI_WRITE, dbg_state}), 64'(0));
    check({tag, "_data"}, 64'({STATUS, RDATA, BPI_DOUT}), 64'(0));
    check({tag, "_addr"}, 64'(BPI_ADDR), 64'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [2:0] c, input logic [AW-1:0] a, input logic [15:0] w);
    @(negedge CLK);
    CMD = c; ADDR = a; WDATA = w; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Returns the number of clock edges after the START edge at which DONE is seen.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- interface FSM model ----------------
  initial begin
    BPI_BUSY = 1'b0;
    BPI_LOAD = 1'b0;
    BPI_DIN  = 16'h0000;
    forever begin
      @(negedge CLK);
      if (BPI_EXECUTE) begin
        check("exec_while_busy", 64'(BPI_BUSY), 64'(0));
        check("exec_rw_onehot", 64'(BPI_READ ^ BPI_WRITE), 64'(1));
        act_q.push_back(enc(BPI_READ, BPI_ADDR, BPI_DOUT));
        bus_rd  = BPI_READ;
        bus_ph  = 0;
        bus_act = 1'b1;
        BPI_LOAD = 1'b0;
      end else if (bus_act) begin
        bus_ph++;
        BPI_BUSY = !stuck && (bus_ph <= (bus_rd ? 7 : 4));
        BPI_LOAD = !stuck && bus_rd && (bus_ph == 6);
        if (BPI_LOAD) BPI_DIN = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
        if (bus_ph > (bus_rd ? 7 : 4)) bus_act = 1'b0;
      end
    end
  end

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    int lat, wr_hold, done_k, done_n;
    RST = 1'b1; START = 1'b0; CMD = 3'd0; ADDR = '0; WDATA = 16'h0000;

    //                 cmd   addr        wdata    nr  responses                                  err  tmo  status  rdata    lat reads
    vecs[0]  = mk(3'd2, 23'h000100, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h00, 16'h0000, 7,  0);
    vecs[1]  = mk(3'd1, 23'h000200, 16'h0000, 1, 16'h5580, 16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h80, 16'h0000, 17, 1);
    vecs[2]  = mk(3'd0, 23'h7FFFFF, 16'h0000, 1, 16'hBEEF, 16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h80, 16'hBEEF, 17, 1);
    vecs[3]  = mk(3'd3, 23'h012345, 16'hA5A5, 4, 16'h1100, 16'h2200, 16'h3300, 16'h4480, 1'b0, 1'b0, 8'h80, 16'hBEEF, 54, 4);
    vecs[4]  = mk(3'd4, 23'h000400, 16'h0000, 1, 16'h00A0, 16'h0,    16'h0,    16'h0,    1'b1, 1'b0, 8'hA0, 16'hBEEF, 24, 1);
    vecs[5]  = mk(3'd3, 23'h000500, 16'h1234, 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'h00, 16'hBEEF, 54, 4);
    vecs[6]  = mk(3'd5, 23'h000800, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h00, 16'hBEEF, 14, 0);
    vecs[7]  = mk(3'd6, 23'h000800, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h00, 16'hBEEF, 14, 0);
    vecs[8]  = mk(3'd7, 23'h000900, 16'h0000, 0, 16'h0,    16'h0,    16'h0,    16'h0,    1'b1, 1'b0, 8'h00, 16'hBEEF, 1,  0);
    vecs[9]  = mk(3'd3, 23'h000A00, 16'h0F0F, 1, 16'h0090, 16'h0,    16'h0,    16'h0,    1'b1, 1'b0, 8'h90, 16'hBEEF, 24, 1);
    vecs[10] = mk(3'd1, 23'h000B00, 16'h0000, 1, 16'hFF02, 16'h0,    16'h0,    16'h0,    1'b0, 1'b0, 8'h02, 16'hBEEF, 17, 1);

    repeat (2) @(negedge CLK);
    #1;
    outputs_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      resp_q.delete();
      if (vecs[i].n_resp > 0) resp_q.push_back(vecs[i].r0);
      if (vecs[i].n_resp > 1) resp_q.push_back(vecs[i].r1);
      if (vecs[i].n_resp > 2) resp_q.push_back(vecs[i].r2);
      if (vecs[i].n_resp > 3) resp_q.push_back(vecs[i].r3);
      build_expected(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].reads);
      start_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_busy_n1", i), 64'(SEQ_BUSY), 64'(1));
      check($sformatf("v%0d_exec_n1", i), 64'(BPI_EXECUTE), 64'(vecs[i].cmd != 3'd7));
      wait_done(100, lat);
      check($sformatf("v%0d_done_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_err", i), 64'(ERR), 64'(vecs[i].err));
      check($sformatf("v%0d_tmo", i), 64'(TMO), 64'(vecs[i].tmo));
      check($sformatf("v%0d_status", i), 64'(STATUS), 64'(vecs[i].status));
      check($sformatf("v%0d_rdata", i), 64'(RDATA), 64'(vecs[i].rdata));
      check($sformatf("v%0d_busy_at_done", i), 64'(SEQ_BUSY), 64'(0));
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_done_pulse", i), 64'({DONE, SEQ_BUSY}), 64'(0));
      compare_bus($sformatf("v%0d", i));
    end

    // START while a command is running is ignored; WRITE stays up through the cycle.
    build_expected(3'd2, 23'h000333, 16'h0000, 0);
    start_cmd(3'd2, 23'h000333, 16'h0000);
    wr_hold = 0; done_k = -1; done_n = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 5 && BPI_WRITE && !BPI_READ && BPI_DOUT == 16'h0050) wr_hold++;
      if (DONE) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (k == 2) begin START = 1'b1; CMD = 3'd4; end
      if (k == 3) START = 1'b0;
      @(posedge CLK);
      #1;
    end
    check("ign_wr_hold", 64'(wr_hold), 64'(5));
    check("ign_done_cycle", 64'(done_k), 64'(8));
    check("ign_done_once", 64'(done_n), 64'(1));
    check("ign_err", 64'(ERR), 64'(0));
    compare_bus("ign");

    // BUSY never rises: ACK timeout.
    stuck = 1'b1;
    build_expected(3'd2, 23'h000444, 16'h0000, 0);
    start_cmd(3'd2, 23'h000444, 16'h0000);
    wait_done(40, lat);
    check("ack_tmo_lat", 64'(lat >= ACK_MAX + 1 && lat <= ACK_MAX + 2), 64'(1));
    check("ack_tmo_tmo", 64'(TMO), 64'(1));
    check("ack_tmo_err", 64'(ERR), 64'(1));
    compare_bus("ack_tmo");
    repeat (8) @(posedge CLK);
    stuck = 1'b0;

    // Reset in the middle of an erase, then a normal command.
    resp_q.delete();
    start_cmd(3'd4, 23'h000555, 16'h0000);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    bus_act = 1'b0; BPI_BUSY = 1'b0; BPI_LOAD = 1'b0;
    #1;
    outputs_zero("mid_rst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    act_q.delete();
    exp_q.delete();
    build_expected(3'd2, 23'h000666, 16'h0000, 0);
    start_cmd(3'd2, 23'h000666, 16'h0000);
    wait_done(40, lat);
    check("post_rst_lat", 64'(lat), 64'(7));
    check("post_rst_err", 64'({ERR, TMO}), 64'(0));
    check("post_rst_status", 64'(STATUS), 64'(0));
    compare_bus("post_rst");

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
